// File: rtl/rf_wb_queue.sv
// ---------------------------------------------------------------------------
// rf_wb_queue
//   Write-back queue between the datapath write-back stage and the register
//   file write port. Requests are accepted on a valid/ready handshake,
//   buffered in order in a circular buffer, and drained at most one per
//   cycle into the RF. An optional forwarding lookup lets the read side see
//   values that are queued but not yet committed.
//
//   Build option: define WBQ_FWD_EN to compile in the forwarding lookup.
//   When it is undefined, the hit/fwd outputs are tied to 0.
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   write-back request present
//   in_ready  out  queue can accept a request (count != DEPTH)
//   in_addr   in   [4:0]  destination register index
//   in_data   in   [31:0] destination register value
//   drain_en  in   permits draining the head entry this cycle
//   write     out  RF write enable
//   Rd_addr   out  [4:0]  RF write address (head entry, 0 when empty)
//   Rd_data   out  [31:0] RF write data (head entry, 0 when empty)
//   Rs_addr   in   [4:0]  lookup address from RF read port s
//   Rt_addr   in   [4:0]  lookup address from RF read port t
//   Rs_hit    out  a pending entry matches Rs_addr
//   Rt_hit    out  a pending entry matches Rt_addr
//   Rs_fwd    out  [31:0] youngest matching pending value for Rs_addr
//   Rt_fwd    out  [31:0] youngest matching pending value for Rt_addr
// ---------------------------------------------------------------------------
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        drain_en,
    output logic        write,
    output logic [4:0]  Rd_addr,
    output logic [31:0] Rd_data,
    input  logic [4:0]  Rs_addr,
    input  logic [4:0]  Rt_addr,
    output logic        Rs_hit,
    output logic        Rt_hit,
    output logic [31:0] Rs_fwd,
    output logic [31:0] Rt_fwd
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic push;
    logic pop;

    // in_ready depends on count only, so a full queue refuses a push even
    // when the head is popped in the same cycle.
    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready;
    assign write    = (count_q != '0) && drain_en && !rst;
    assign pop      = write;

    always_comb begin
        Rd_addr = '0;
        Rd_data = '0;
        if (count_q != '0) begin
            Rd_addr = addr_q[head_q];
            Rd_data = data_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                addr_q[tail_q] <= in_addr;
                data_q[tail_q] <= in_data;
            end
        end
    end

`ifdef WBQ_FWD_EN
    // Scan oldest to youngest; a later match overwrites an earlier one so
    // the entry closest to tail wins.
    always_comb begin
        logic [AW-1:0] idx;
        Rs_hit = 1'b0;
        Rs_fwd = '0;
        Rt_hit = 1'b0;
        Rt_fwd = '0;
        idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if ((AW+1)'(i) < count_q) begin
                if (addr_q[idx] == Rs_addr) begin
                    Rs_hit = 1'b1;
                    Rs_fwd = data_q[idx];
                end
                if (addr_q[idx] == Rt_addr) begin
                    Rt_hit = 1'b1;
                    Rt_fwd = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^{Rs_addr, Rt_addr};
    assign Rs_hit = 1'b0;
    assign Rt_hit = 1'b0;
    assign Rs_fwd = '0;
    assign Rt_fwd = '0;
`endif

endmodule
